// File: rtl/clken_gen_pkg.sv
// Shared types and limits for the clock-enable generator.
package clken_gen_pkg;

  localparam int unsigned MaxChannels = 8;

  typedef enum logic [0:0] {
    StWait,
    StLocked
  } lock_state_e;

endpackage

// File: rtl/clken_chan.sv
// One clock-enable channel: latched divisor/phase, wrapping counter, registered enable
// and (with CLKEN_GEN_DUTY_EN defined) a registered divided square wave.
module clken_chan
  import clken_gen_pkg::*;
#(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             load,
  input  logic [DIV_W-1:0] div_i,
  input  logic [DIV_W-1:0] phase_i,
  input  logic             lock_next_i,
  output logic             ce_o,
  output logic             clk_o
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             ce_q, ce_d;

  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    if (load) begin
      div_d = div_i;
      cnt_d = (phase_i < div_i) ? phase_i : '0;
    end else if (div_q == '0 || cnt_q == div_q - DIV_W'(1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
    // Outputs are computed from next state so the registered value lines up with C.
    ce_d = (div_d != '0) && (cnt_d == div_d - DIV_W'(1)) && lock_next_i;
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      div_q <= DIV_W'(DEFAULT_DIV);
      cnt_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
      ce_q  <= ce_d;
    end
  end

  assign ce_o = ce_q;

`ifdef CLKEN_GEN_DUTY_EN
  logic clk_q;

  always_ff @(posedge clkin) begin
    if (reset) begin
      clk_q <= 1'b0;
    end else begin
      clk_q <= (cnt_d < (div_d >> 1));
    end
  end

  assign clk_o = clk_q;
`else
  assign clk_o = 1'b0;
`endif

endmodule

// File: rtl/clken_gen.sv
// Multi-channel clock-enable generator with a shared startup lock FSM.
// Optional feature macro: CLKEN_GEN_DUTY_EN (divided square wave on clk_o).
module clken_gen
  import clken_gen_pkg::*;
#(
  parameter int unsigned CHANNELS       = 2,
  parameter int unsigned DIV_W          = 8,
  parameter int unsigned DEFAULT_DIV    = 4,
  parameter int unsigned STARTUP_CYCLES = 16
) (
  input  logic                      clkin,
  input  logic                      reset,
  input  logic                      load,
  input  logic [CHANNELS*DIV_W-1:0] div_i,
  input  logic [CHANNELS*DIV_W-1:0] phase_i,
  output logic [CHANNELS-1:0]       ce_o,
  output logic [CHANNELS-1:0]       clk_o,
  output logic                      lock_o
);

  localparam int unsigned CntW = (STARTUP_CYCLES > 0) ? $clog2(STARTUP_CYCLES + 1) : 1;

  if (CHANNELS < 1 || CHANNELS > MaxChannels) begin : gen_bad_channels
    $error("clken_gen: CHANNELS out of range");
  end

  lock_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            lock_next;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (load) begin
      state_d = StWait;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StWait: begin
          // cnt_q counts completed settle cycles; lock on the STARTUP_CYCLES-th one.
          if ((int'(cnt_q) + 1) >= int'(STARTUP_CYCLES)) begin
            state_d = StLocked;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StLocked: state_d = StLocked;
        default:  state_d = StWait;
      endcase
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q <= StWait;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign lock_next = (state_d == StLocked);
  assign lock_o    = (state_q == StLocked);

  for (genvar k = 0; k < int'(CHANNELS); k++) begin : gen_chan
    clken_chan #(
      .DIV_W      (DIV_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_chan (
      .clkin      (clkin),
      .reset      (reset),
      .load       (load),
      .div_i      (div_i[k*DIV_W +: DIV_W]),
      .phase_i    (phase_i[k*DIV_W +: DIV_W]),
      .lock_next_i(lock_next),
      .ce_o       (ce_o[k]),
      .clk_o      (clk_o[k])
    );
  end

endmodule

// File: tb/tb_clken_gen.sv
// Randomized self-checking bench for clken_gen against a phase/elapsed-time reference model.
module tb_clken_gen;

  localparam int unsigned CH = 2;
  localparam int unsigned W  = 8;
  localparam int unsigned S  = 16;

  logic            clkin = 1'b0;
  logic            reset = 1'b1;
  logic            load  = 1'b0;
  logic [CH*W-1:0] div_i   = '0;
  logic [CH*W-1:0] phase_i = '0;
  logic [CH-1:0]   ce_o;
  logic [CH-1:0]   clk_o;
  logic            lock_o;

  clken_gen #(
    .CHANNELS      (CH),
    .DIV_W         (W),
    .DEFAULT_DIV   (4),
    .STARTUP_CYCLES(S)
  ) dut (
    .clkin  (clkin),
    .reset  (reset),
    .load   (load),
    .div_i  (div_i),
    .phase_i(phase_i),
    .ce_o   (ce_o),
    .clk_o  (clk_o),
    .lock_o (lock_o)
  );

  always #5 clkin = ~clkin;

  // Model: each channel is (divisor, start phase, cycles since restart); C = (phase + t) mod D.
  int md[CH];
  int mp[CH];
  int mt[CH];
  int mn;
  bit mr;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [CH*W-1:0] pack2(input int a, input int b);
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    lo = W'(a);
    hi = W'(b);
    return {hi, lo};
  endfunction

  task automatic step(input bit rst, input bit ld, input logic [CH*W-1:0] dv,
                      input logic [CH*W-1:0] ph);
    int  c;
    bit  lk;
    bit  exp_ce;
    bit  exp_clk;
    reset   = rst;
    load    = ld;
    div_i   = dv;
    phase_i = ph;
    @(posedge clkin);
    for (int k = 0; k < int'(CH); k++) begin
      if (rst) begin
        md[k] = 4;
        mp[k] = 0;
        mt[k] = 0;
      end else if (ld) begin
        md[k] = int'(dv[k*W +: W]);
        mp[k] = (int'(ph[k*W +: W]) < md[k]) ? int'(ph[k*W +: W]) : 0;
        mt[k] = 0;
      end else begin
        mt[k]++;
      end
    end
    if (rst || ld) mn = 0;
    else mn++;
    mr = rst;
    #1;
    lk = (mn >= int'(S));
    check("lock", 32'(lock_o), 32'(lk));
    for (int k = 0; k < int'(CH); k++) begin
      c = (md[k] == 0) ? 0 : (mp[k] + mt[k]) % md[k];
      exp_ce = (md[k] != 0) && (c == md[k] - 1) && lk;
`ifdef CLKEN_GEN_DUTY_EN
      exp_clk = !mr && (md[k] != 0) && (c < md[k] / 2);
`else
      exp_clk = 1'b0;
`endif
      check($sformatf("ce%0d", k), 32'(ce_o[k]), 32'(exp_ce));
      check($sformatf("clk%0d", k), 32'(clk_o[k]), 32'(exp_clk));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, CH*W'($urandom), CH*W'($urandom));
    end
  endtask

  initial begin
    // Power-up reset, then default divisor 4 and startup lock.
    step(1'b1, 1'b0, '0, '0);
    idle(24);
    // Two different divisors, ch1 with a start phase.
    step(1'b0, 1'b1, pack2(3, 5), pack2(0, 2));
    idle(30);
    // Disabled channel.
    step(1'b0, 1'b1, pack2(3, 0), pack2(1, 0));
    idle(30);
    // Phase out of range falls back to 0.
    step(1'b0, 1'b1, pack2(6, 6), pack2(9, 9));
    idle(30);
    // Reset wins over simultaneous load; reload 5 cycles into WAIT.
    step(1'b1, 1'b1, pack2(2, 7), pack2(1, 3));
    idle(5);
    step(1'b0, 1'b1, pack2(4, 7), pack2(1, 3));
    idle(20);
    // Divide by one.
    step(1'b0, 1'b1, pack2(1, 1), pack2(0, 5));
    idle(20);
    // Mid-period reset.
    step(1'b0, 1'b1, pack2(7, 9), pack2(2, 4));
    idle(22);
    step(1'b1, 1'b0, '0, '0);
    idle(20);
    // Random loads, resets and junk on the data inputs while load is low.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(299) == 0) begin
        step(1'b1, 1'(($urandom_range(1))), CH*W'($urandom), CH*W'($urandom));
      end else if ($urandom_range(39) == 0) begin
        step(1'b0, 1'b1, pack2(int'($urandom_range(9)), int'($urandom_range(9))),
             pack2(int'($urandom_range(11)), int'($urandom_range(11))));
      end else begin
        step(1'b0, 1'b0, CH*W'($urandom), CH*W'($urandom));
      end
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/clken_gen.md
CLKEN_GEN -- requirements
Module: clken_gen

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent clock-enable channels (1..8).
REQ-002 SHALL have parameter DIV_W, default 8: width of each channel's divisor and phase fields.
REQ-003 SHALL have parameter DEFAULT_DIV, default 4: divisor loaded into every channel at reset.
REQ-004 SHALL have parameter STARTUP_CYCLES, default 16: settle time, in clkin cycles, before lock_o asserts.
REQ-005 SHALL have port clkin  input  1: single clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-007 SHALL have port load  input  1: one-cycle strobe that applies div_i/phase_i to all channels.
REQ-008 SHALL have port div_i  input  CHANNELS*DIV_W: per-channel divisor; channel k occupies bits [k*DIV_W +: DIV_W].
REQ-009 SHALL have port phase_i  input  CHANNELS*DIV_W: per-channel start phase, packed as div_i.
REQ-010 SHALL have port ce_o  output  CHANNELS: per-channel one-cycle enable pulse.
REQ-011 SHALL have port clk_o  output  CHANNELS: per-channel divided square wave (fabric signal, not a clock net).
REQ-012 SHALL have port lock_o  output  1: high once all channels have run STARTUP_CYCLES since the last reset/load.

Function
REQ-013 Each channel SHALL hold a latched divisor D, latched phase P and a counter C cycling 0..D-1, wrapping D-1 -> 0.
REQ-014 Raw enable for a channel SHALL be high in exactly the cycles where C == D-1, giving one pulse every D cycles.
REQ-015 ce_o[k] SHALL equal raw enable k AND lock_o; ce_o SHALL be low whenever lock_o is low.
REQ-016 D == 0 SHALL disable the channel: counter held at 0, ce_o and clk_o low.
REQ-017 D == 1 SHALL make raw enable constant high and clk_o low.
REQ-018 On load, C SHALL be set to P when P < D, otherwise to 0; all channels restart in the same cycle.
REQ-019 Settings latched on load SHALL take effect in the cycle after the strobe; div_i/phase_i SHALL be ignored when load is low.
REQ-020 A lock FSM SHALL have states WAIT and LOCKED; WAIT counts STARTUP_CYCLES cycles then moves to LOCKED (lock_o high).
REQ-021 load in any state SHALL return the FSM to WAIT with its count cleared; load during WAIT restarts the count.
REQ-022 Startup count width SHALL be $clog2(STARTUP_CYCLES+1); STARTUP_CYCLES == 0 SHALL give LOCKED in the cycle after reset/load.
REQ-023 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-024 reset SHALL take priority over load in the same cycle.
REQ-025 On reset: D = DEFAULT_DIV, P = 0, C = 0 for every channel; FSM = WAIT, count 0; ce_o = 0, clk_o = 0, lock_o = 0.
REQ-026 reset asserted mid-period SHALL abandon the period; counting resumes from C = 0 in the cycle after reset deasserts.

Configuration
REQ-027 Macro CLKEN_GEN_DUTY_EN SHALL, when defined, generate clk_o[k] high while C < floor(D/2), else low (50% duty for even D).
REQ-028 Without CLKEN_GEN_DUTY_EN, clk_o SHALL be tied to 0 and the duty comparators SHALL not be generated; ce_o and lock_o are unchanged.

Structure
REQ-029 A shared package clken_gen_pkg SHALL hold the lock FSM state enum (WAIT, LOCKED) and the CHANNELS maximum constant (8).
REQ-030 Per-channel counter, latch and duty logic SHALL live in one sub-module clken_chan, instantiated CHANNELS times via generate.

Verification
REQ-031 Reset, DEFAULT_DIV=4, STARTUP_CYCLES=16 -> lock_o rises 16 cycles after reset release; then ce_o[0] pulses every 4th cycle.
REQ-032 load with ch0 D=3,P=0 and ch1 D=5,P=2 -> lock_o drops next cycle; after relock, ch0 pulses every 3 cycles, ch1 every 5, first ch1 pulse 2 cycles after restart.
REQ-033 load with D=0 on ch1 -> ce_o[1] and clk_o[1] stay 0 indefinitely; ch0 unaffected.
REQ-034 load with D=6, P=9 (P >= D) -> counter starts at 0; clk_o high 3 cycles, low 3 cycles (DUTY_EN defined); clk_o constant 0 without it.
REQ-035 reset and load asserted in the same cycle -> reset values result, load ignored; load again 5 cycles into WAIT -> lock_o asserts 16 cycles after the second load.
REQ-036 D=1 after lock -> ce_o high every cycle, clk_o low.
